// File: rtl/usbfs_pkt_tx.sv
// rtl/usbfs_pkt_tx.sv - Full-speed USB handshake/DATA packet transmitter with bit stuffing and NRZI
module usbfs_pkt_tx #(
  parameter int MAX_PKT = 8
) (
  input  logic                       i_clk_48MHz,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic [3:0]                 i_pid,
  input  logic [$clog2(MAX_PKT):0]   i_nBytes,
  output logic                       o_rdEn,
  output logic [$clog2(MAX_PKT)-1:0] o_rdIdx,
  input  logic [7:0]                 i_rdByte,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_oe,
  output logic                       o_dp,
  output logic                       o_dn
);
  localparam int IW = $clog2(MAX_PKT);
  localparam logic [IW:0] MAX_LEN = (IW+1)'(MAX_PKT);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_phase;
  logic [3:0]    r_cnt, w_cnt;
  logic [IW:0]   r_idx, w_idx, r_nbytes, w_nbytes, w_idx_inc;
  logic          r_is_data, w_is_data;
  logic [7:0]    r_shift, w_shift, r_hold;
  logic [15:0]   r_crc, w_crc;
  logic [2:0]    r_ones, w_ones;
  logic          r_line, w_line;
  logic          r_rd_d1;
  logic          r_rden, w_rden;
  logic [IW-1:0] r_rdidx, w_rdidx;
  logic          r_busy, w_busy, r_done, w_done;
  logic          r_oe, w_oe, r_dp, w_dp, r_dn, w_dn;
  logic          w_bit, w_send;

  assign w_idx_inc = r_idx + (IW+1)'(1);

  // Registers; reset returns the pads to an undriven J immediately
  always_ff @(posedge i_clk_48MHz or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_phase   <= 2'd0;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_nbytes  <= '0;
      r_is_data <= 1'b0;
      r_shift   <= 8'd0;
      r_hold    <= 8'd0;
      r_crc     <= 16'd0;
      r_ones    <= 3'd0;
      r_line    <= 1'b1;
      r_rd_d1   <= 1'b0;
      r_rden    <= 1'b0;
      r_rdidx   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_oe      <= 1'b0;
      r_dp      <= 1'b1;
      r_dn      <= 1'b0;
    end else begin
      r_phase   <= r_phase + 2'd1;
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_nbytes  <= w_nbytes;
      r_is_data <= w_is_data;
      r_shift   <= w_shift;
      r_crc     <= w_crc;
      r_ones    <= w_ones;
      r_line    <= w_line;
      r_rd_d1   <= r_rden;
      if (r_rd_d1) r_hold <= i_rdByte;
      r_rden    <= w_rden;
      r_rdidx   <= w_rdidx;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_oe      <= w_oe;
      r_dp      <= w_dp;
      r_dn      <= w_dn;
    end
  end

  // Next state: one bus-bit decision per phase-3 cycle; a pending stuff bit pre-empts the field
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_nbytes  = r_nbytes;
    w_is_data = r_is_data;
    w_shift   = r_shift;
    w_crc     = r_crc;
    w_ones    = r_ones;
    w_line    = r_line;
    w_rden    = 1'b0;
    w_rdidx   = r_rdidx;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_oe      = r_oe;
    w_dp      = r_dp;
    w_dn      = r_dn;
    w_bit     = 1'b0;
    w_send    = 1'b0;
    if (r_state == S_IDLE) begin
      w_oe = 1'b0;
      w_dp = 1'b1;
      w_dn = 1'b0;
      if (i_start) begin
        w_state   = S_SYNC;
        w_busy    = 1'b1;
        w_cnt     = 4'd0;
        w_idx     = '0;
        w_crc     = 16'hFFFF;
        w_ones    = 3'd0;
        w_line    = 1'b1;
        w_shift   = {~i_pid, i_pid};
        w_is_data = (i_pid[1:0] == 2'b11);
        if (i_pid[1:0] != 2'b11)   w_nbytes = '0;
        else if (i_nBytes > MAX_LEN) w_nbytes = MAX_LEN;
        else                       w_nbytes = i_nBytes;
      end
    end else if (r_phase == 2'd3) begin
      if (r_ones == 3'd6 && (r_state != S_EOP || r_cnt == 4'd0)) begin
        w_line = ~r_line;
        w_ones = 3'd0;
        w_oe   = 1'b1;
        w_dp   = ~r_line;
        w_dn   = r_line;
      end else begin
        case (r_state)
          S_SYNC: begin
            w_bit  = (r_cnt == 4'd7);
            w_send = 1'b1;
            if (r_cnt == 4'd7) begin
              w_state = S_PID;
              w_cnt   = 4'd0;
            end else w_cnt = r_cnt + 4'd1;
          end
          S_PID: begin
            w_bit   = r_shift[0];
            w_send  = 1'b1;
            w_shift = {1'b0, r_shift[7:1]};
            if (r_cnt == 4'd0 && r_nbytes != '0) begin
              w_rden  = 1'b1;
              w_rdidx = '0;
            end
            if (r_cnt == 4'd7) begin
              w_cnt   = 4'd0;
              w_idx   = '0;
              w_shift = r_hold;
              if (!r_is_data)          w_state = S_EOP;
              else if (r_nbytes == '0) w_state = S_CRC;
              else                     w_state = S_DATA;
            end else w_cnt = r_cnt + 4'd1;
          end
          S_DATA: begin
            w_bit   = r_shift[0];
            w_send  = 1'b1;
            w_shift = {1'b0, r_shift[7:1]};
            w_crc   = {r_crc[14:0], 1'b0} ^ ((r_shift[0] ^ r_crc[15]) ? 16'h8005 : 16'h0000);
            if (r_cnt == 4'd0 && w_idx_inc < r_nbytes) begin
              w_rden  = 1'b1;
              w_rdidx = w_idx_inc[IW-1:0];
            end
            if (r_cnt == 4'd7) begin
              w_cnt   = 4'd0;
              w_shift = r_hold;
              if (w_idx_inc == r_nbytes) w_state = S_CRC;
              else                       w_idx   = w_idx_inc;
            end else w_cnt = r_cnt + 4'd1;
          end
          S_CRC: begin
            w_bit  = ~r_crc[15];
            w_send = 1'b1;
            w_crc  = {r_crc[14:0], 1'b1};
            if (r_cnt == 4'd15) begin
              w_state = S_EOP;
              w_cnt   = 4'd0;
            end else w_cnt = r_cnt + 4'd1;
          end
          S_EOP: begin
            w_cnt = r_cnt + 4'd1;
            w_oe  = 1'b1;
            if (r_cnt == 4'd0 || r_cnt == 4'd1) begin
              w_dp = 1'b0;
              w_dn = 1'b0;
            end else if (r_cnt == 4'd2) begin
              w_dp = 1'b1;
              w_dn = 1'b0;
            end else begin
              w_state = S_IDLE;
              w_cnt   = 4'd0;
              w_oe    = 1'b0;
              w_dp    = 1'b1;
              w_dn    = 1'b0;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end
          end
          default: w_state = S_IDLE;
        endcase
        if (w_send) begin
          w_line = w_bit ? r_line : ~r_line;
          w_ones = w_bit ? r_ones + 3'd1 : 3'd0;
          w_oe   = 1'b1;
          w_dp   = w_bit ? r_line : ~r_line;
          w_dn   = w_bit ? ~r_line : r_line;
        end
      end
    end
  end

  assign o_rdEn  = r_rden;
  assign o_rdIdx = r_rdidx;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_oe    = r_oe;
  assign o_dp    = r_dp;
  assign o_dn    = r_dn;
endmodule

// File: tb/tb_usbfs_pkt_tx.sv
// tb/tb_usbfs_pkt_tx.sv - Randomised model-based bench for usbfs_pkt_tx
module tb_usbfs_pkt_tx;
  localparam int MAX_PKT = 8;
  localparam int IW = $clog2(MAX_PKT);
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] ACK_LINE [19] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
                                           LJ, LJ, LK, LJ, LJ, LK, LK, LK,
                                           L0, L0, LJ};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    pid = 4'd0;
  logic [IW:0]   nbytes = '0;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_byte = 8'd0;
  logic          busy, done, oe, dp, dn;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] pay [MAX_PKT];
  logic [1:0] exp_line [$];
  int         fetch_at [$];

  always #10 clk = ~clk;

  usbfs_pkt_tx #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk_48MHz(clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_pid      (pid),
    .i_nBytes   (nbytes),
    .o_rdEn     (rd_en),
    .o_rdIdx    (rd_idx),
    .i_rdByte   (rd_byte),
    .o_busy     (busy),
    .o_done     (done),
    .o_oe       (oe),
    .o_dp       (dp),
    .o_dn       (dn)
  );

  // Caller-owned buffer: answers a fetch one cycle later, garbage otherwise
  always @(posedge clk) rd_byte <= rd_en ? pay[rd_idx] : 8'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16_usb(input logic [7:0] b [$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[k]) begin
      c ^= {8'h00, b[k]};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected bus levels per bit time and fetch cycles, from the packet rules
  task automatic build_model(input logic [3:0] p, input int nreq);
    logic       bits [$];
    int         li [$];
    logic [7:0] bytes [$];
    logic [15:0] crc;
    logic       line;
    int         ones, nb;
    nb = (p[1:0] == 2'b11) ? ((nreq > MAX_PKT) ? MAX_PKT : nreq) : 0;
    exp_line.delete();
    fetch_at.delete();
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    for (int i = 0; i < 8; i++) bits.push_back((i < 4) ? p[i] : ~p[i-4]);
    if (p[1:0] == 2'b11) begin
      for (int k = 0; k < nb; k++) bytes.push_back(pay[k]);
      crc = crc16_usb(bytes);
      for (int k = 0; k < nb; k++)
        for (int i = 0; i < 8; i++) bits.push_back(pay[k][i]);
      for (int i = 0; i < 16; i++) bits.push_back(crc[i]);
    end
    line = 1'b1;
    ones = 0;
    foreach (bits[i]) begin
      li.push_back(exp_line.size());
      if (!bits[i]) line = ~line;
      exp_line.push_back(line ? LJ : LK);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line = ~line;
        exp_line.push_back(line ? LJ : LK);
        ones = 0;
      end
    end
    exp_line.push_back(L0);
    exp_line.push_back(L0);
    exp_line.push_back(LJ);
    for (int k = 0; k < nb; k++) fetch_at.push_back(4 * li[8 + 8*k]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", {oe, dp, dn, busy, done, rd_en}, 6'b010000);
    end
  endtask

  // Sends one packet from a negedge and compares every cycle against the model
  task automatic run_packet(input logic [3:0] p, input int nreq, input int glitch_at, input int abort_at);
    int   lat, n, exp_idx;
    logic exp_rd, aborted;
    build_model(p, nreq);
    n = exp_line.size();
    aborted = 1'b0;
    pid = p;
    nbytes = (IW+1)'(nreq);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pid = 4'($urandom);
    nbytes = (IW+1)'($urandom);
    check("busy_rise", busy, 1);
    lat = 0;
    while (!oe && lat < 5) begin
      check("pre_sync_line", {dp, dn, done}, 3'b100);
      @(negedge clk);
      lat++;
    end
    check("sync_latency", (lat >= 1 && lat <= 4), 1);
    for (int c = 0; c < 4*n; c++) begin
      if (c == glitch_at) begin
        start = 1'b1;
        pid = 4'($urandom);
        nbytes = (IW+1)'($urandom);
      end
      if (c == glitch_at + 1) start = 1'b0;
      if (c == abort_at) begin
        rstn = 1'b0;
        #1;
        check("abort_async", {oe, dp, dn, busy, done, rd_en}, 6'b010000);
        @(negedge clk);
        check("abort_held", {oe, dp, dn, busy, done, rd_en, 29'(rd_idx)}, {6'b010000, 29'd0});
        rstn = 1'b1;
        aborted = 1'b1;
        break;
      end
      exp_rd = 1'b0;
      exp_idx = 0;
      foreach (fetch_at[k]) if (fetch_at[k] == c) begin
        exp_rd = 1'b1;
        exp_idx = k;
      end
      check("line", {oe, dp, dn, busy, done, rd_en}, {1'b1, exp_line[c/4], 1'b1, 1'b0, exp_rd});
      if (exp_rd) check("rd_idx", 32'(rd_idx), 32'(exp_idx));
      @(negedge clk);
    end
    if (!aborted) check("done", {oe, dp, dn, busy, done}, 5'b01001);
  endtask

  initial begin
    logic [7:0] q [$];
    int mism;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [$];
    int mism;
    // Model pins against hand-derived values
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check", crc16_usb(q), 16'h374B ^ 16'h8383);
    q.delete();
    check("model_crc_empty", crc16_usb(q), 16'h0000);
    build_model(4'h2, 0);
    mism = 0;
    for (int i = 0; i < 19; i++) if (i >= exp_line.size() || exp_line[i] != ACK_LINE[i]) mism++;
    check("model_ack_line", exp_line.size() * 100 + mism, 1900);
    build_model(4'h3, 0);
    check("model_data0_len", exp_line.size(), 35);
    pay[0] = 8'hFF;
    pay[1] = 8'hFF;
    build_model(4'hB, 2);
    check("model_data1_len", exp_line.size(), 56);
    check("model_data1_stuff", (exp_line[22] != exp_line[21]) && (exp_line[21] == exp_line[16]), 1);
    check("model_data1_fetch", fetch_at[1], 64);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {oe, dp, dn, busy, done, rd_en, 29'(rd_idx)}, {6'b010000, 29'd0});
    rstn = 1'b1;
    idle(3);

    // ACK, empty DATA0, DATA1 {FF,FF}
    run_packet(4'h2, 5, -10, -10);
    idle(2);
    run_packet(4'h3, 0, -10, -10);
    idle(3);
    run_packet(4'hB, 2, -10, -10);
    idle(1);

    // Length clamp
    for (int k = 0; k < MAX_PKT; k++) pay[k] = 8'($urandom);
    run_packet(4'h3, MAX_PKT + 1, -10, -10);
    idle(2);

    // Second start while busy is ignored
    for (int k = 0; k < MAX_PKT; k++) pay[k] = 8'($urandom);
    run_packet(4'h3, 4, 50, -10);
    idle(12);

    // Reset mid-DATA, then a clean packet
    run_packet(4'hB, 8, -10, 150);
    idle(3);
    for (int k = 0; k < MAX_PKT; k++) pay[k] = 8'($urandom);
    run_packet(4'hB, 3, -10, -10);

    // Random packets, some back to back from the done cycle
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < MAX_PKT; k++) pay[k] = 8'($urandom);
      idle($urandom_range(0, 5));
      run_packet(4'($urandom), $urandom_range(0, 15), -10, -10);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
